// File: rtl/expansion_fifo_responder.sv
// Card-side expansion connector responder: synchronised host strobes, four byte registers,
// and TX/RX byte FIFOs bridging host accesses to card-local valid/ready logic.
module expansion_fifo_responder #(
    parameter logic [7:0]  BASE_ADDR  = 8'h00,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       s_oszClk,
    input  logic       s_resetn,
    input  logic       i_ioNCE,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    input  logic [7:0] i_ioAddress,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busNOE,
    input  logic [7:0] i_rxData,
    input  logic       i_rxValid,
    output logic [7:0] o_txData,
    output logic       o_txValid,
    input  logic       i_txReady
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic          r_nceS1, r_nceS2, r_noeS1, r_noeS2, r_nweS1, r_nweS2;
    logic [7:0]    r_addrS1, r_addrS2, r_dataS1, r_dataS2;
    logic          r_noeP, r_nweP, r_selP;
    logic [1:0]    r_idxP;
    logic [7:0]    r_wdata, r_scratch, r_bus;
    logic          r_busNOE, r_rxOvf, r_txOvf;
    logic [PW-1:0] r_rxWr, r_rxRd, r_txWr, r_txRd;
    logic [7:0]    r_rxMem [FIFO_DEPTH];
    logic [7:0]    r_txMem [FIFO_DEPTH];

    logic       w_sel, w_commit, w_wrData, w_wrCtrl, w_clear, w_flush;
    logic       w_rxEmpty, w_rxFull, w_txEmpty, w_txFull;
    logic       w_rxPop, w_rxPush, w_rxOvf, w_txPop, w_txPush, w_txOvf;
    logic [7:0] w_rxHead, w_status, w_rdData;

    assign w_sel     = !r_nceS2 && (r_addrS2[7:2] == BASE_ADDR[7:2]);
    assign w_rxEmpty = (r_rxWr == r_rxRd);
    assign w_txEmpty = (r_txWr == r_txRd);
    assign w_rxFull  = (r_rxWr[AW] != r_rxRd[AW]) && (r_rxWr[AW-1:0] == r_rxRd[AW-1:0]);
    assign w_txFull  = (r_txWr[AW] != r_txRd[AW]) && (r_txWr[AW-1:0] == r_txRd[AW-1:0]);

    // One commit per strobe: NWE rising edge seen in the synchronised domain.
    assign w_commit = r_nweS2 && !r_nweP && r_selP;
    assign w_wrData = w_commit && (r_idxP == 2'd0);
    assign w_wrCtrl = w_commit && (r_idxP == 2'd3);
    assign w_clear  = w_wrCtrl && r_wdata[0];
    assign w_flush  = w_wrCtrl && r_wdata[1];

    // Pop at the end of the read so the driven byte stays stable for the whole strobe.
    assign w_rxPop  = r_noeS2 && !r_noeP && r_selP && (r_idxP == 2'd0) && !w_rxEmpty;
    assign w_rxPush = i_rxValid && (!w_rxFull || w_rxPop);
    assign w_rxOvf  = i_rxValid && w_rxFull && !w_rxPop;
    assign w_txPop  = !w_txEmpty && i_txReady;
    assign w_txPush = w_wrData && (!w_txFull || w_txPop);
    assign w_txOvf  = w_wrData && w_txFull && !w_txPop;

    assign w_rxHead  = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRd[AW-1:0]];
    assign o_txData  = w_txEmpty ? 8'h00 : r_txMem[r_txRd[AW-1:0]];
    assign o_txValid = !w_txEmpty;
    assign w_status  = {2'b00, r_txOvf, r_rxOvf, w_txFull, w_txEmpty, w_rxFull, w_rxEmpty};
    assign o_bus     = r_bus;
    assign o_busNOE  = r_busNOE;

    always_comb begin
        w_rdData = 8'h00;
        unique case (r_addrS2[1:0])
            2'd0: w_rdData = w_rxHead;
            2'd1: w_rdData = w_status;
            2'd2: w_rdData = r_scratch;
            2'd3: w_rdData = 8'h00;
        endcase
    end

    always_ff @(posedge s_oszClk or negedge s_resetn) begin
        if (!s_resetn) begin
            r_nceS1   <= 1'b1;
            r_nceS2   <= 1'b1;
            r_noeS1   <= 1'b1;
            r_noeS2   <= 1'b1;
            r_nweS1   <= 1'b1;
            r_nweS2   <= 1'b1;
            r_addrS1  <= 8'h00;
            r_addrS2  <= 8'h00;
            r_dataS1  <= 8'h00;
            r_dataS2  <= 8'h00;
            r_noeP    <= 1'b1;
            r_nweP    <= 1'b1;
            r_selP    <= 1'b0;
            r_idxP    <= 2'd0;
            r_wdata   <= 8'h00;
            r_scratch <= 8'h00;
            r_bus     <= 8'hff;
            r_busNOE  <= 1'b1;
            r_rxOvf   <= 1'b0;
            r_txOvf   <= 1'b0;
            r_rxWr    <= '0;
            r_rxRd    <= '0;
            r_txWr    <= '0;
            r_txRd    <= '0;
        end else begin
            r_nceS1  <= i_ioNCE;
            r_nceS2  <= r_nceS1;
            r_noeS1  <= i_ioNOE;
            r_noeS2  <= r_noeS1;
            r_nweS1  <= i_ioNWE;
            r_nweS2  <= r_nweS1;
            r_addrS1 <= i_ioAddress;
            r_addrS2 <= r_addrS1;
            r_dataS1 <= i_bus;
            r_dataS2 <= r_dataS1;
            r_noeP   <= r_noeS2;
            r_nweP   <= r_nweS2;
            r_selP   <= w_sel;
            r_idxP   <= r_addrS2[1:0];
            if (!r_nweS2) r_wdata <= r_dataS2;
            if (w_commit && (r_idxP == 2'd2)) r_scratch <= r_wdata;

            r_busNOE <= !(w_sel && !r_noeS2);
            r_bus    <= (w_sel && !r_noeS2) ? w_rdData : 8'hff;

            // A same-cycle overflow event wins over a clear.
            r_rxOvf <= (r_rxOvf && !w_clear) || w_rxOvf;
            r_txOvf <= (r_txOvf && !w_clear) || w_txOvf;

            if (w_flush) begin
                r_rxWr <= '0;
                r_rxRd <= '0;
                r_txWr <= '0;
                r_txRd <= '0;
            end else begin
                if (w_rxPush) r_rxWr <= r_rxWr + PTR_ONE;
                if (w_rxPop)  r_rxRd <= r_rxRd + PTR_ONE;
                if (w_txPush) r_txWr <= r_txWr + PTR_ONE;
                if (w_txPop)  r_txRd <= r_txRd + PTR_ONE;
            end
        end
    end

    always_ff @(posedge s_oszClk) begin
        if (w_rxPush) r_rxMem[r_rxWr[AW-1:0]] <= i_rxData;
        if (w_txPush) r_txMem[r_txWr[AW-1:0]] <= r_wdata;
    end
endmodule

// File: tb/tb_expansion_fifo_responder.sv
// Directed bench for expansion_fifo_responder: register vector table plus
// hand-written FIFO, overflow, flush and reset sequences.
module tb_expansion_fifo_responder;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       nce = 1'b1, noe = 1'b1, nwe = 1'b1;
    logic [7:0] addr = 8'h00, wbus = 8'h00;
    logic [7:0] o_bus, o_txData;
    logic       o_busNOE, o_txValid;
    logic [7:0] rxData = 8'h00;
    logic       rxValid = 1'b0, txReady = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    expansion_fifo_responder #(
        .BASE_ADDR  (8'h00),
        .FIFO_DEPTH (16)
    ) dut (
        .s_oszClk    (clk),
        .s_resetn    (rstn),
        .i_ioNCE     (nce),
        .i_ioNOE     (noe),
        .i_ioNWE     (nwe),
        .i_ioAddress (addr),
        .i_bus       (wbus),
        .o_bus       (o_bus),
        .o_busNOE    (o_busNOE),
        .i_rxData    (rxData),
        .i_rxValid   (rxValid),
        .o_txData    (o_txData),
        .o_txValid   (o_txValid),
        .i_txReady   (txReady)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        wbus = d;
        nce  = 1'b0;
        nwe  = 1'b0;
        tick(4);
        nce = 1'b1;
        nwe = 1'b1;
        tick(4);
    endtask

    // pre: o_busNOE two cycles after NOE falls; post/data: three cycles after.
    task automatic host_read(input logic [7:0] a, output logic pre, output logic post,
                             output logic [7:0] data);
        addr = a;
        nce  = 1'b0;
        noe  = 1'b0;
        tick(2);
        pre = o_busNOE;
        tick(1);
        post = o_busNOE;
        data = o_bus;
        tick(1);
        nce = 1'b1;
        noe = 1'b1;
        tick(4);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        logic       exp_noe;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic       pre, post;
        logic [7:0] rd;

        tick(3);
        check("rst_busNOE", {7'd0, o_busNOE}, 8'h01);
        check("rst_bus", o_bus, 8'hff);
        check("rst_txValid", {7'd0, o_txValid}, 8'h00);
        check("rst_txData", o_txData, 8'h00);
        rstn = 1'b1;
        tick(3);

        vecs[0] = '{1'b0, 8'h01, 8'h00, 1'b0, 8'h05};
        vecs[1] = '{1'b1, 8'h02, 8'h5A, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h02, 8'h00, 1'b0, 8'h5A};
        vecs[3] = '{1'b0, 8'h03, 8'h00, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 8'h02, 8'hA5, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h02, 8'h00, 1'b0, 8'hA5};
        vecs[7] = '{1'b0, 8'h06, 8'h00, 1'b1, 8'hff};
        vecs[8] = '{1'b1, 8'h06, 8'h33, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 8'h02, 8'h00, 1'b0, 8'hA5};

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                host_write(vecs[i].a, vecs[i].d);
            end else begin
                host_read(vecs[i].a, pre, post, rd);
                check($sformatf("vec%0d_pre", i), {7'd0, pre}, 8'h01);
                check($sformatf("vec%0d_noe", i), {7'd0, post}, {7'd0, vecs[i].exp_noe});
                check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
            end
        end

        // RX push then host DATA reads
        rxData = 8'h11; rxValid = 1'b1; tick(1);
        rxData = 8'h22; tick(1);
        rxValid = 1'b0;
        host_read(8'h01, pre, post, rd);
        check("rx_status_two", rd, 8'h04);
        host_read(8'h00, pre, post, rd);
        check("rx_first", rd, 8'h11);
        host_read(8'h00, pre, post, rd);
        check("rx_second", rd, 8'h22);
        host_read(8'h00, pre, post, rd);
        check("rx_empty_read", rd, 8'h00);
        host_read(8'h01, pre, post, rd);
        check("rx_status_empty", rd, 8'h05);

        // TX fill past depth with consumer stalled
        for (int i = 0; i < 17; i++) host_write(8'h00, 8'(i));
        host_read(8'h01, pre, post, rd);
        check("tx_full_ovf", rd, 8'h29);
        check("tx_head_stalled", o_txData, 8'h00);
        txReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_valid%0d", i), {7'd0, o_txValid}, 8'h01);
            check($sformatf("tx_data%0d", i), o_txData, 8'(i));
            tick(1);
        end
        check("tx_drained_valid", {7'd0, o_txValid}, 8'h00);
        check("tx_drained_data", o_txData, 8'h00);
        txReady = 1'b0;
        host_write(8'h03, 8'h01);
        host_read(8'h01, pre, post, rd);
        check("ovf_cleared", rd, 8'h05);

        // RX full, push coincides with the end-of-read pop
        rxValid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rxData = 8'h80 + 8'(i);
            tick(1);
        end
        rxValid = 1'b0;
        host_read(8'h01, pre, post, rd);
        check("rx_full_status", rd, 8'h06);
        addr = 8'h00; nce = 1'b0; noe = 1'b0;
        tick(4);
        check("rx_full_head", o_bus, 8'h80);
        nce = 1'b1; noe = 1'b1;
        tick(2);
        rxData = 8'h9F; rxValid = 1'b1;
        tick(1);
        rxValid = 1'b0;
        tick(3);
        host_read(8'h01, pre, post, rd);
        check("rx_pushpop_full", rd, 8'h06);
        for (int i = 1; i < 16; i++) begin
            host_read(8'h00, pre, post, rd);
            check($sformatf("rx_drain%0d", i), rd, 8'h80 + 8'(i));
        end
        host_read(8'h00, pre, post, rd);
        check("rx_drain_last", rd, 8'h9F);

        // Flush + clear with both FIFOs occupied and an RX overflow pending
        rxValid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rxData = 8'(i);
            tick(1);
        end
        rxValid = 1'b0;
        host_write(8'h00, 8'h44);
        host_read(8'h01, pre, post, rd);
        check("pre_flush_status", rd, 8'h12);
        host_write(8'h03, 8'h03);
        host_read(8'h01, pre, post, rd);
        check("post_flush_status", rd, 8'h05);
        check("post_flush_txValid", {7'd0, o_txValid}, 8'h00);

        // Reset in the middle of a SCRATCH write strobe
        host_write(8'h00, 8'h99);
        check("pre_rst_txValid", {7'd0, o_txValid}, 8'h01);
        addr = 8'h02; wbus = 8'h77; nce = 1'b0; nwe = 1'b0;
        tick(4);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_txValid", {7'd0, o_txValid}, 8'h00);
        check("async_rst_txData", o_txData, 8'h00);
        check("async_rst_busNOE", {7'd0, o_busNOE}, 8'h01);
        check("async_rst_bus", o_bus, 8'hff);
        nce = 1'b1; nwe = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(3);
        host_read(8'h02, pre, post, rd);
        check("rst_no_commit", rd, 8'h00);
        host_read(8'h01, pre, post, rd);
        check("rst_status", rd, 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
